// File: rtl/trng_key_buffer.sv
// trng_key_buffer
//   Harvests 32-bit keys from the TRNG core using a 4-phase handshake
//   (key_ready / ack_read). It stores them in a first-word-fall-through FIFO
//   and presents them to the system on a valid/ready read port. A rising
//   edge on the TRNG failure interrupt flushes every stored key and latches
//   a sticky failure flag.
//
//   State table (capture FSM):
//     state | meaning
//     IDLE  | waiting for a key that can be stored
//     ACK   | key written; holding ack_read_o until key_ready_i drops
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   enable_i         harvesting enable (gates only the start of a capture)
//   key_ready_i      TRNG key valid
//   key_i            TRNG key word
//   trng_intr_i      TRNG health-test failure interrupt
//   ack_read_o       handshake acknowledge back to the TRNG
//   rd_valid_o       FIFO head valid
//   rd_data_o        FIFO head word (zero when empty)
//   rd_ready_i       consumer accepts the head word
//   level_o          number of stored words
//   full_o, empty_o  FIFO status
//   fail_o           sticky failure flag
//   clear_fail_i     clears fail_o when the interrupt is low
module trng_key_buffer #(
    parameter int N_BITS_KEY = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable_i,
    input  logic                     key_ready_i,
    input  logic [N_BITS_KEY-1:0]    key_i,
    input  logic                     trng_intr_i,
    output logic                     ack_read_o,
    output logic                     rd_valid_o,
    output logic [N_BITS_KEY-1:0]    rd_data_o,
    input  logic                     rd_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     fail_o,
    input  logic                     clear_fail_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_DEPTH = LVL_W'(DEPTH);

    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [N_BITS_KEY-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [LVL_W-1:0]        level;
    logic                    intr_q;
    logic                    fail;
    logic                    flush;
    logic                    push;
    logic                    pop;

    // Status derives from the registered level only.
    assign full_o  = (level == LVL_DEPTH);
    assign empty_o = (level == '0);
    assign level_o = level;
    assign fail_o  = fail;

    // Flush fires on the rising edge of the interrupt and beats push/pop.
    assign flush = trng_intr_i && !intr_q;
    assign push  = (state == IDLE) && enable_i && key_ready_i &&
                   !full_o && !fail && !flush;
    assign pop   = rd_valid_o && rd_ready_i && !flush;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A flush does not abort a handshake in progress.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (push)         state_nxt = ACK;
            ACK:  if (!key_ready_i) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        ack_read_o = 1'b0;
        if (state == ACK) begin
            ack_read_o = 1'b1;
        end
    end

    // Interrupt edge detect and sticky failure flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intr_q <= 1'b0;
            fail   <= 1'b0;
        end else begin
            intr_q <= trng_intr_i;
            if (flush) begin
                fail <= 1'b1;
            end else if (clear_fail_i && !trng_intr_i) begin
                fail <= 1'b0;
            end
        end
    end

    // Pointers and level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset; an empty FIFO masks the read data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= key_i;
        end
    end

    assign rd_valid_o = !empty_o;
    assign rd_data_o  = empty_o ? '0 : mem[rd_ptr];

endmodule
